// File: rtl/mdu_iter.sv
// mdu_iter: iterative radix-2 multiply/divide unit for the RV M-extension
// (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
//
// Operands are converted to sign/magnitude on accept. XLEN shift-add (multiply)
// or restoring-subtract (divide) iterations run on the magnitudes, one bit per
// cycle. The sign correction is folded into the last iteration cycle, so the
// result takes no extra cycle.
// Divide-by-zero and signed overflow skip the iterations and complete in one cycle.
//
// Ports:
//   clk         clock, rising edge
//   rst_n       synchronous active-low reset
//   flush       kills any in-flight or pending op (priority over everything)
//   in_valid    op request valid
//   in_ready    unit idle and able to accept
//   in_op       RV funct3 selecting the operation
//   in_a, in_b  rs1 / rs2 operands (latched on accept)
//   in_tag      opaque tag echoed on out_tag
//   out_valid   result valid (held until out_ready)
//   out_ready   consumer accepts result
//   out_result  result, holds last value outside DONE
//   out_tag     tag of the op that produced out_result
module mdu_iter #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int PW    = 2 * XLEN;
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    // Two's-complement negate when neg is set.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + XLEN'(1)) : v;
    endfunction

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
    function automatic logic op_a_signed(input logic [2:0] op);
        logic s;
        case (op)
            OP_MULH, OP_MULHSU, OP_DIV, OP_REM: s = 1'b1;
            default:                            s = 1'b0;
        endcase
        return s;
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM.
    function automatic logic op_b_signed(input logic [2:0] op);
        logic s;
        case (op)
            OP_MULH, OP_DIV, OP_REM: s = 1'b1;
            default:                 s = 1'b0;
        endcase
        return s;
    endfunction

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [2:0]         op_r;
    logic [TAG_W-1:0]   tag_r;
    logic [XLEN-1:0]    b_mag_r;
    logic [PW-1:0]      acc_r;
    logic               neg_q_r;
    logic               neg_r_r;
    logic [XLEN-1:0]    result_r;
    logic [TAG_W-1:0]   out_tag_r;
    logic               out_valid_r;

    logic               accept_s;
    logic               a_neg_s, b_neg_s;
    logic [XLEN-1:0]    a_mag_s, b_mag_s;
    logic               div_zero_s, div_ovf_s, fast_s;
    logic [XLEN-1:0]    fast_result_s;
    logic [XLEN:0]      mul_sum_s;
    logic [PW-1:0]      mul_nxt_s;
    logic [XLEN:0]      div_shl_s, div_dif_s;
    logic               div_ge_s;
    logic [XLEN-1:0]    div_rem_s;
    logic [PW-1:0]      div_nxt_s;
    logic [PW-1:0]      acc_nxt_s;
    logic [PW-1:0]      prod_s;
    logic [XLEN-1:0]    calc_result_s;

    assign in_ready   = rst_n && (state_r == IDLE);
    assign accept_s   = in_valid && in_ready && !flush;
    assign out_valid  = out_valid_r;
    assign out_result = result_r;
    assign out_tag    = out_tag_r;

    // Decode the incoming op: magnitudes, sign flags and the one-cycle special cases.
    always_comb begin
        a_neg_s       = op_a_signed(in_op) & in_a[XLEN-1];
        b_neg_s       = op_b_signed(in_op) & in_b[XLEN-1];
        a_mag_s       = cond_neg(in_a, a_neg_s);
        b_mag_s       = cond_neg(in_b, b_neg_s);
        div_zero_s    = in_op[2] & (in_b == ZERO);
        div_ovf_s     = in_op[2] & ~in_op[0] & (in_a == INT_MIN) & (in_b == ALL_ONES);
        fast_s        = div_zero_s | div_ovf_s;
        fast_result_s = ZERO;
        if (div_zero_s) begin
            fast_result_s = in_op[1] ? in_a : ALL_ONES;
        end else if (div_ovf_s) begin
            fast_result_s = in_op[1] ? ZERO : in_a;
        end else begin
            fast_result_s = ZERO;
        end
    end

    // One iteration step. acc_r holds {partial product, multiplier} for multiply
    // and {partial remainder, dividend/quotient} for divide.
    always_comb begin
        mul_sum_s = {1'b0, acc_r[PW-1:XLEN]}
                  + (acc_r[0] ? {1'b0, b_mag_r} : {(XLEN+1){1'b0}});
        mul_nxt_s = {mul_sum_s, acc_r[XLEN-1:1]};
        div_shl_s = {acc_r[PW-1:XLEN], acc_r[XLEN-1]};
        div_ge_s  = (div_shl_s >= {1'b0, b_mag_r});
        div_dif_s = div_shl_s - {1'b0, b_mag_r};
        div_rem_s = div_ge_s ? div_dif_s[XLEN-1:0] : div_shl_s[XLEN-1:0];
        div_nxt_s = {div_rem_s, acc_r[XLEN-2:0], div_ge_s};
        acc_nxt_s = op_r[2] ? div_nxt_s : mul_nxt_s;
    end

    // Sign-corrected final result, formed from the last iteration's output.
    always_comb begin
        prod_s = neg_q_r ? (~acc_nxt_s + PW'(1)) : acc_nxt_s;
        case (op_r)
            OP_MUL:                       calc_result_s = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: calc_result_s = prod_s[PW-1:XLEN];
            OP_DIV, OP_DIVU:              calc_result_s = cond_neg(acc_nxt_s[XLEN-1:0], neg_q_r);
            OP_REM, OP_REMU:              calc_result_s = cond_neg(acc_nxt_s[PW-1:XLEN], neg_r_r);
            default:                      calc_result_s = ZERO;
        endcase
    end

    // Next-state logic; flush overrides accept and the output handshake.
    always_comb begin
        state_s = state_r;
        if (flush) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_s = fast_s ? DONE : CALC;
                    end else begin
                        state_s = IDLE;
                    end
                end
                CALC: begin
                    if (cnt_r == CNT_LAST) begin
                        state_s = DONE;
                    end else begin
                        state_s = CALC;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_s = IDLE;
                    end else begin
                        state_s = DONE;
                    end
                end
                default: state_s = IDLE;
            endcase
        end
    end

    // State register and the registered out_valid that mirrors the DONE state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            out_valid_r <= (state_s == DONE);
        end
    end

    // Datapath: latch the op on accept, iterate in CALC, register the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r     <= {CNT_W{1'b0}};
            op_r      <= 3'b000;
            tag_r     <= {TAG_W{1'b0}};
            b_mag_r   <= ZERO;
            acc_r     <= {PW{1'b0}};
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            result_r  <= ZERO;
            out_tag_r <= {TAG_W{1'b0}};
        end else if (accept_s) begin
            cnt_r   <= {CNT_W{1'b0}};
            op_r    <= in_op;
            tag_r   <= in_tag;
            b_mag_r <= b_mag_s;
            acc_r   <= {ZERO, a_mag_s};
            neg_q_r <= a_neg_s ^ b_neg_s;
            neg_r_r <= a_neg_s;
            if (fast_s) begin
                result_r  <= fast_result_s;
                out_tag_r <= in_tag;
            end
        end else if ((state_r == CALC) && !flush) begin
            acc_r <= acc_nxt_s;
            cnt_r <= cnt_r + CNT_W'(1);
            if (cnt_r == CNT_LAST) begin
                result_r  <= calc_result_s;
                out_tag_r <= tag_r;
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
module tb_mdu_iter;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid_v [2];
    logic        flush_v    [2];
    logic        out_ready_v[2];
    logic [2:0]  op_v       [2];
    logic [63:0] a_v        [2];
    logic [63:0] b_v        [2];
    logic [4:0]  tag_v      [2];

    wire         in_ready_0, in_ready_1, out_valid_0, out_valid_1;
    wire [4:0]   out_tag_0, out_tag_1;
    wire [63:0]  out_result_0;
    wire [31:0]  out_result_1;

    int checks = 0;
    int errors = 0;

    mdu_iter #(.XLEN(64), .TAG_W(5)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush_v[0]),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_0), .in_op(op_v[0]),
        .in_a(a_v[0]), .in_b(b_v[0]), .in_tag(tag_v[0]),
        .out_valid(out_valid_0), .out_ready(out_ready_v[0]),
        .out_result(out_result_0), .out_tag(out_tag_0)
    );

    mdu_iter #(.XLEN(32), .TAG_W(5)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush_v[1]),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_1), .in_op(op_v[1]),
        .in_a(a_v[1][31:0]), .in_b(b_v[1][31:0]), .in_tag(tag_v[1]),
        .out_valid(out_valid_1), .out_ready(out_ready_v[1]),
        .out_result(out_result_1), .out_tag(out_tag_1)
    );

    function automatic logic f_rdy(input int u);
        return (u == 0) ? in_ready_0 : in_ready_1;
    endfunction

    function automatic logic f_ov(input int u);
        return (u == 0) ? out_valid_0 : out_valid_1;
    endfunction

    function automatic logic [63:0] f_res(input int u);
        return (u == 0) ? out_result_0 : {32'd0, out_result_1};
    endfunction

    function automatic logic [4:0] f_tag(input int u);
        return (u == 0) ? out_tag_0 : out_tag_1;
    endfunction

    // Independent reference: wide arithmetic on sign/zero-extended operands.
    function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [63:0] a,
                                           input logic [63:0] b, input int w);
        logic signed [127:0] sa, sb, q;
        logic [127:0]        ua, ub, p;
        logic [63:0]         r, mask;
        mask = (w == 32) ? 64'h0000_0000_FFFF_FFFF : ONES;
        if (w == 32) begin
            sa = {{96{a[31]}}, a[31:0]};
            sb = {{96{b[31]}}, b[31:0]};
            ua = {96'd0, a[31:0]};
            ub = {96'd0, b[31:0]};
        end else begin
            sa = {{64{a[63]}}, a};
            sb = {{64{b[63]}}, b};
            ua = {64'd0, a};
            ub = {64'd0, b};
        end
        p = 128'd0;
        q = 128'sd0;
        case (op)
            3'b000: begin p = ua * ub; r = p[63:0]; end
            3'b001: begin p = sa * sb; p = p >> w; r = p[63:0]; end
            3'b010: begin p = sa * ub; p = p >> w; r = p[63:0]; end
            3'b011: begin p = ua * ub; p = p >> w; r = p[63:0]; end
            3'b100: begin if (ub == 128'd0) r = ONES; else begin q = sa / sb; r = q[63:0]; end end
            3'b101: begin if (ub == 128'd0) r = ONES; else begin p = ua / ub; r = p[63:0]; end end
            3'b110: begin if (ub == 128'd0) r = a; else begin q = sa % sb; r = q[63:0]; end end
            default: begin if (ub == 128'd0) r = a; else begin p = ua % ub; r = p[63:0]; end end
        endcase
        return r & mask;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Issue one op on unit u and check latency, result, tag and the handshake.
    task automatic run_op(input int u, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] tag,
                          input logic [63:0] exp, input int exp_lat, input string name);
        int lat;
        logic [63:0] mask;
        mask = (u == 1) ? 64'h0000_0000_FFFF_FFFF : ONES;
        lat = 0;
        while (!f_rdy(u) && lat < 200) begin step; lat++; end
        check({name, " in_ready"}, {63'd0, f_rdy(u)}, 64'd1);
        op_v[u] = op; a_v[u] = a; b_v[u] = b; tag_v[u] = tag; in_valid_v[u] = 1'b1;
        step;
        in_valid_v[u] = 1'b0;
        a_v[u] = {$urandom, $urandom};
        b_v[u] = {$urandom, $urandom};
        tag_v[u] = ~tag;
        lat = 1;
        while (!f_ov(u) && lat < 200) begin step; lat++; end
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " result"}, f_res(u), exp & mask);
        check({name, " tag"}, {59'd0, f_tag(u)}, {59'd0, tag});
        out_ready_v[u] = 1'b1;
        step;
        out_ready_v[u] = 1'b0;
        check({name, " out_valid drop"}, {63'd0, f_ov(u)}, 64'd0);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[17];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vecs[0]  = '{3'b000, ONES, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 65};
        vecs[1]  = '{3'b001, ONES, 64'd2, ONES, 65};
        vecs[2]  = '{3'b010, ONES, 64'd2, ONES, 65};
        vecs[3]  = '{3'b011, ONES, 64'd2, 64'd1, 65};
        vecs[4]  = '{3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
        vecs[5]  = '{3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 65};
        vecs[6]  = '{3'b101, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'h7FFF_FFFF_FFFF_FFFC, 65};
        vecs[7]  = '{3'b111, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'd1, 65};
        vecs[8]  = '{3'b100, 64'd5, 64'd0, ONES, 1};
        vecs[9]  = '{3'b111, 64'd5, 64'd0, 64'd5, 1};
        vecs[10] = '{3'b100, MIN, ONES, MIN, 1};
        vecs[11] = '{3'b110, MIN, ONES, 64'd0, 1};
        vecs[12] = '{3'b011, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 65};
        vecs[13] = '{3'b001, MIN, MIN, 64'h4000_0000_0000_0000, 65};
        vecs[14] = '{3'b101, 64'd100, 64'd7, 64'd14, 65};
        vecs[15] = '{3'b110, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65};
        vecs[16] = '{3'b100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65};

        for (int u = 0; u < 2; u++) begin
            in_valid_v[u] = 1'b1; flush_v[u] = 1'b0; out_ready_v[u] = 1'b0;
            op_v[u] = 3'b100; a_v[u] = 64'd5; b_v[u] = 64'd0; tag_v[u] = 5'd3;
        end

        // Reset held two cycles with a request pending.
        rst_n = 1'b0;
        step;
        step;
        check("reset in_ready", {63'd0, in_ready_0}, 64'd0);
        check("reset out_valid", {63'd0, out_valid_0}, 64'd0);
        check("reset out_result", out_result_0, 64'd0);
        check("reset out_tag", {59'd0, out_tag_0}, 64'd0);
        check("reset out_valid 32", {63'd0, out_valid_1}, 64'd0);
        rst_n = 1'b1;
        in_valid_v[0] = 1'b0;
        in_valid_v[1] = 1'b0;
        step;
        check("release in_ready", {63'd0, in_ready_0}, 64'd1);
        check("release in_ready 32", {63'd0, in_ready_1}, 64'd1);

        // Directed table on the 64-bit unit.
        for (int i = 0; i < 17; i++) begin
            run_op(0, vecs[i].op, vecs[i].a, vecs[i].b, 5'(i), vecs[i].exp, vecs[i].lat,
                   $sformatf("vec%0d", i));
        end

        // Backpressure: result held stable in DONE while out_ready is low.
        op_v[0] = 3'b100; a_v[0] = 64'd5; b_v[0] = 64'd0; tag_v[0] = 5'd9; in_valid_v[0] = 1'b1;
        step;
        in_valid_v[0] = 1'b0;
        check("bp out_valid", {63'd0, out_valid_0}, 64'd1);
        for (int k = 0; k < 10; k++) begin
            step;
            check("bp hold valid", {63'd0, out_valid_0}, 64'd1);
            check("bp hold result", out_result_0, ONES);
            check("bp hold tag", {59'd0, out_tag_0}, 64'd9);
            check("bp in_ready", {63'd0, in_ready_0}, 64'd0);
        end
        out_ready_v[0] = 1'b1;
        step;
        out_ready_v[0] = 1'b0;
        check("bp release valid", {63'd0, out_valid_0}, 64'd0);
        check("bp release ready", {63'd0, in_ready_0}, 64'd1);
        op_v[0] = 3'b011; a_v[0] = ONES; b_v[0] = 64'd2; tag_v[0] = 5'd10; in_valid_v[0] = 1'b1;
        step;
        in_valid_v[0] = 1'b0;
        check("bp next accepted", {63'd0, in_ready_0}, 64'd0);
        begin
            int lat;
            lat = 1;
            while (!out_valid_0 && lat < 200) begin step; lat++; end
            check("bp next latency", 64'(lat), 64'd65);
            check("bp next result", out_result_0, 64'd1);
            check("bp next tag", {59'd0, out_tag_0}, 64'd10);
        end
        out_ready_v[0] = 1'b1;
        step;
        out_ready_v[0] = 1'b0;

        // Flush in CALC at counter 30: op is dropped without a result.
        op_v[0] = 3'b000; a_v[0] = 64'd3; b_v[0] = 64'd4; tag_v[0] = 5'd21; in_valid_v[0] = 1'b1;
        step;
        in_valid_v[0] = 1'b0;
        repeat (30) step;
        flush_v[0] = 1'b1;
        step;
        flush_v[0] = 1'b0;
        check("flush calc in_ready", {63'd0, in_ready_0}, 64'd1);
        check("flush calc out_valid", {63'd0, out_valid_0}, 64'd0);
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 100; k++) begin
                step;
                if (out_valid_0) seen = 1'b1;
            end
            check("flush calc no result", {63'd0, seen}, 64'd0);
        end

        // Flush in IDLE with a request: must not be accepted.
        op_v[0] = 3'b100; a_v[0] = 64'd5; b_v[0] = 64'd0; tag_v[0] = 5'd22;
        in_valid_v[0] = 1'b1; flush_v[0] = 1'b1;
        step;
        in_valid_v[0] = 1'b0; flush_v[0] = 1'b0;
        check("flush idle in_ready", {63'd0, in_ready_0}, 64'd1);
        check("flush idle out_valid", {63'd0, out_valid_0}, 64'd0);
        step;
        check("flush idle out_valid later", {63'd0, out_valid_0}, 64'd0);

        // Constrained random ops against the reference on both widths.
        for (int u = 0; u < 2; u++) begin
            for (int n = 0; n < 24; n++) begin
                logic [2:0]  op;
                logic [63:0] a, b, mask, mn;
                logic [4:0]  tag;
                int          lat;
                mask = (u == 1) ? 64'h0000_0000_FFFF_FFFF : ONES;
                mn   = (u == 1) ? 64'h0000_0000_8000_0000 : MIN;
                op   = 3'($urandom_range(0, 7));
                case ($urandom_range(0, 5))
                    0:       a = mn;
                    1:       a = mask;
                    2:       a = 64'd0;
                    default: a = {$urandom, $urandom} & mask;
                endcase
                case ($urandom_range(0, 5))
                    0:       b = 64'd0;
                    1:       b = mask;
                    2:       b = 64'd1;
                    default: b = {$urandom, $urandom} & mask;
                endcase
                tag = 5'($urandom_range(0, 31));
                if (op[2] && ((b == 64'd0) || (!op[0] && a == mn && b == mask))) begin
                    lat = 1;
                end else begin
                    lat = (u == 1) ? 33 : 65;
                end
                run_op(u, op, a, b, tag, ref_op(op, a, b, (u == 1) ? 32 : 64), lat,
                       $sformatf("rnd u%0d n%0d op%0d", u, n, op));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
